// File: rtl/memoria_pkg.sv
// Shared definitions for the data-memory response block: FSM states, word width
// and default latency/depth.
package memoria_pkg;

    localparam int LARGURA_PALAVRA     = 32;
    localparam int LATENCIA_PADRAO     = 2;
    localparam int PROFUNDIDADE_PADRAO = 256;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

endpackage

// File: rtl/memoria_array.sv
// Single-port word storage: synchronous write, registered read.
// Contents are never cleared; the read register only moves when a read is enabled.
module memoria_array
    import memoria_pkg::*;
#(
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int AW           = $clog2(PROFUNDIDADE_PADRAO)
) (
    input  logic                       clock,
    input  logic                       escrita,
    input  logic                       leitura,
    input  logic [AW-1:0]              endereco,
    input  logic [LARGURA_PALAVRA-1:0] dadoEscrita,
    output logic [LARGURA_PALAVRA-1:0] dadoLeitura
);

    logic [LARGURA_PALAVRA-1:0] palavras [PROFUNDIDADE];

    always_ff @(posedge clock) begin
        if (escrita) begin
            palavras[endereco] <= dadoEscrita;
        end
        if (leitura) begin
            dadoLeitura <= palavras[endereco];
        end
    end

endmodule

// File: rtl/memoria_dados_resp.sv
// MEM-stage data memory with fixed access latency and a one-cycle response pulse.
// Optional macro MEM_ERRO_ALINHAMENTO_EN turns misaligned accesses into error responses.
module memoria_dados_resp
    import memoria_pkg::*;
#(
    parameter int LATENCIA     = LATENCIA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(PROFUNDIDADE);

    estado_t                    estado;
    logic [3:0]                 contador;
    logic                       respValid;
    logic                       rdataValida;
    logic                       escritaQ;
    logic [AW-1:0]              indiceQ;
    logic [LARGURA_PALAVRA-1:0] wdataQ;
    logic [LARGURA_PALAVRA-1:0] arrRdata;
    logic                       misQ;
    logic                       conclui;
    logic                       escreve;
    logic                       le;
    logic                       aceita;
    logic                       unusedAddr;

    // Upper address bits wrap; the byte offset only matters for the error build.
    assign unusedAddr = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign aceita  = (estado == OCIOSO) && req_valid;
    assign conclui = (estado == ACESSO) && (contador == 4'd0);
    assign escreve = conclui && escritaQ && !misQ && !reset;
    assign le      = conclui && !escritaQ && !misQ && !reset;

    always_ff @(posedge clock) begin
        if (aceita) begin
            escritaQ <= req_write;
            indiceQ  <= req_addr[AW+1:2];
            wdataQ   <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            contador    <= 4'd0;
            respValid   <= 1'b0;
            rdataValida <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    respValid <= 1'b0;
                    if (req_valid) begin
                        estado   <= ACESSO;
                        contador <= 4'(LATENCIA - 1);
                    end
                end
                ACESSO: begin
                    if (contador == 4'd0) begin
                        estado    <= RESPOSTA;
                        respValid <= 1'b1;
                        if (!escritaQ) begin
                            rdataValida <= !misQ;
                        end
                    end else begin
                        contador <= contador - 4'd1;
                    end
                end
                RESPOSTA: begin
                    estado    <= OCIOSO;
                    respValid <= 1'b0;
                end
                default: begin
                    estado    <= OCIOSO;
                    respValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ERRO_ALINHAMENTO_EN
    logic errQ;

    always_ff @(posedge clock) begin
        if (aceita) begin
            misQ <= (req_addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            errQ <= 1'b0;
        end else begin
            errQ <= conclui && misQ;
        end
    end

    assign resp_err = errQ;
`else
    assign misQ     = 1'b0;
    assign resp_err = 1'b0;
`endif

    memoria_array #(
        .PROFUNDIDADE(PROFUNDIDADE),
        .AW          (AW)
    ) uArray (
        .clock      (clock),
        .escrita    (escreve),
        .leitura    (le),
        .endereco   (indiceQ),
        .dadoEscrita(wdataQ),
        .dadoLeitura(arrRdata)
    );

    assign busy       = (estado != OCIOSO);
    assign resp_valid = respValid;
    // Zero after reset or after an error response, otherwise the last loaded word.
    assign resp_rdata = rdataValida ? arrRdata : '0;

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Bench for memoria_dados_resp: directed scenarios plus random traffic against a
// word-array reference model, on a LATENCIA=2 instance and a LATENCIA=1 instance.
module tb_memoria_dados_resp;

`ifdef MEM_ERRO_ALINHAMENTO_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int LAT0 = 2;
    localparam int DEP0 = 256;
    localparam int LAT1 = 1;
    localparam int DEP1 = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst0, rv0, rw0, busy0, vld0, err0;
    logic [31:0] ra0, wd0, rdata0;
    logic rst1, rv1, rw1, busy1, vld1, err1;
    logic [31:0] ra1, wd1, rdata1;

    memoria_dados_resp #(.LATENCIA(LAT0), .PROFUNDIDADE(DEP0)) dut0 (
        .clock(clock), .reset(rst0), .req_valid(rv0), .req_write(rw0),
        .req_addr(ra0), .req_wdata(wd0), .busy(busy0), .resp_valid(vld0),
        .resp_rdata(rdata0), .resp_err(err0)
    );

    memoria_dados_resp #(.LATENCIA(LAT1), .PROFUNDIDADE(DEP1)) dut1 (
        .clock(clock), .reset(rst1), .req_valid(rv1), .req_write(rw1),
        .req_addr(ra1), .req_wdata(wd1), .busy(busy1), .resp_valid(vld1),
        .resp_rdata(rdata1), .resp_err(err1)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] m0 [DEP0];
    bit          k0 [DEP0];
    logic [31:0] m1 [DEP1];
    logic [31:0] lastRd0 = 32'h0;
    logic [31:0] lastRd1 = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; returns edges from acceptance to the pulse and busy cycles.
    task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat, output int bc);
        @(negedge clock);
        if (sel) begin rv1 = 1'b1; rw1 = w; ra1 = a; wd1 = d; end
        else     begin rv0 = 1'b1; rw0 = w; ra0 = a; wd0 = d; end
        @(posedge clock); #1;
        rv0 = 1'b0; rv1 = 1'b0;
        lat = 0; bc = 0;
        while (!(sel ? vld1 : vld0) && lat < 20) begin
            if (sel ? busy1 : busy0) bc++;
            @(posedge clock); #1;
            lat++;
        end
        if (sel ? busy1 : busy0) bc++;
        rd = sel ? rdata1 : rdata0;
        er = sel ? err1 : err0;
        @(posedge clock); #1;
        if (sel ? busy1 : busy0) bc++;
        check("pulse_one_cycle", {31'b0, (sel ? vld1 : vld0)}, 32'h0);
    endtask

    task automatic doOp(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
        int depth, expLat, idx, lat, bc;
        bit mis;
        logic [31:0] rd, expRd;
        logic er;
        depth  = sel ? DEP1 : DEP0;
        expLat = sel ? LAT1 : LAT0;
        idx    = int'((a >> 2) % depth);
        mis    = ERR_EN && (a[1:0] != 2'b00);
        access(sel, w, a, d, rd, er, lat, bc);
        check({tag, "_latency"}, lat, expLat);
        check({tag, "_busy_cycles"}, bc, expLat + 1);
        check({tag, "_err"}, {31'b0, er}, {31'b0, mis});
        if (w) begin
            expRd = sel ? lastRd1 : lastRd0;
            if (!mis) begin
                if (sel) m1[idx] = d;
                else begin m0[idx] = d; k0[idx] = 1'b1; end
            end
        end else begin
            expRd = mis ? 32'h0 : (sel ? m1[idx] : m0[idx]);
            if (sel) lastRd1 = expRd; else lastRd0 = expRd;
        end
        check({tag, "_rdata"}, rd, expRd);
        check({tag, "_rdata_hold"}, sel ? rdata1 : rdata0, sel ? lastRd1 : lastRd0);
    endtask

    initial begin
        int pulses, gap, lastK, idleCyc, nKnown, idx;
        logic [31:0] a, d;
        logic w;

        rst0 = 1'b1; rst1 = 1'b1;
        rv0 = 0; rw0 = 0; ra0 = 0; wd0 = 0;
        rv1 = 0; rw1 = 0; ra1 = 0; wd1 = 0;
        repeat (3) @(posedge clock);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        check("reset_busy", {31'b0, busy0}, 32'h0);
        check("reset_valid", {31'b0, vld0}, 32'h0);
        check("reset_rdata", rdata0, 32'h0);
        check("reset_err", {31'b0, err0}, 32'h0);

        doOp(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10");
        doOp(1'b0, 1'b0, 32'h10, 32'h0, "load_10");

        doOp(1'b0, 1'b1, 32'h400, 32'h00001234, "store_400");
        doOp(1'b0, 1'b0, 32'h000, 32'h0, "load_wrap_000");

        doOp(1'b0, 1'b1, 32'h20, 32'h11111111, "store_20");

        // Request held continuously: accepted once per LAT0+2 edges.
        @(negedge clock);
        rv0 = 1'b1; rw0 = 1'b1; ra0 = 32'h40; wd0 = 32'hCAFE0001;
        pulses = 0; lastK = -1; idleCyc = 0;
        for (int k = 0; k < 4 * (LAT0 + 2); k++) begin
            @(posedge clock); #1;
            if (!busy0) idleCyc++;
            if (vld0) begin
                pulses++;
                if (lastK >= 0) begin
                    gap = k - lastK;
                    check("held_spacing", gap, LAT0 + 2);
                end
                lastK = k;
            end
        end
        rv0 = 1'b0;
        check("held_pulses", pulses, 4);
        check("held_idle_cycles", idleCyc, 4);
        m0[16] = 32'hCAFE0001; k0[16] = 1'b1;
        doOp(1'b0, 1'b0, 32'h40, 32'h0, "load_40_after_hold");

        // Reset one edge into ACESSO aborts the store.
        @(negedge clock);
        rv0 = 1'b1; rw0 = 1'b1; ra0 = 32'h20; wd0 = 32'hAAAA5555;
        @(posedge clock); #1;
        rv0 = 1'b0; rst0 = 1'b1;
        @(posedge clock); #1;
        rst0 = 1'b0;
        check("abort_busy", {31'b0, busy0}, 32'h0);
        check("abort_rdata", rdata0, 32'h0);
        lastRd0 = 32'h0;
        pulses = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (vld0) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        doOp(1'b0, 1'b0, 32'h20, 32'h0, "load_20_after_abort");

        // Reset on the completing edge beats the write.
        @(negedge clock);
        rv0 = 1'b1; rw0 = 1'b1; ra0 = 32'h20; wd0 = 32'h55550000;
        @(posedge clock); #1;
        rv0 = 1'b0;
        repeat (LAT0 - 1) @(posedge clock);
        #1;
        rst0 = 1'b1;
        @(posedge clock); #1;
        rst0 = 1'b0;
        check("late_reset_valid", {31'b0, vld0}, 32'h0);
        lastRd0 = 32'h0;
        doOp(1'b0, 1'b0, 32'h20, 32'h0, "load_20_after_late_reset");

        doOp(1'b0, 1'b0, 32'h22, 32'h0, "load_misaligned_22");

        doOp(1'b1, 1'b1, 32'h4, 32'h00000005, "l1_store_4");
        doOp(1'b1, 1'b0, 32'h4, 32'h0, "l1_load_4");
        doOp(1'b1, 1'b0, 32'h44, 32'h0, "l1_load_wrap_44");

        for (int n = 0; n < 40; n++) begin
            nKnown = 0;
            for (int i = 0; i < DEP0; i++) if (k0[i]) nKnown++;
            w = ($urandom_range(0, 1) == 1) || (nKnown == 0);
            if (w) begin
                idx = $urandom_range(0, DEP0 - 1);
            end else begin
                idx = $urandom_range(0, DEP0 - 1);
                while (!k0[idx]) idx = (idx + 1) % DEP0;
            end
            a = ($urandom() & 32'hFFFF_FC00) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            d = $urandom();
            doOp(1'b0, w, a, d, w ? "rand_store" : "rand_load");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
